// File: rtl/dot_accum_unit.sv
// rtl/dot_accum_unit.sv - multi-lane dot-product accumulator with registered adder tree
//
// Purpose:
//   Each accepted beat multiplies LANES operand pairs (S1), reduces the products
//   through a balanced adder tree (S2) and folds the tree sum into a per-vector
//   accumulator (S3). A vector ends on in_last or when MAX_BEATS beats have been
//   accepted. Operand signedness and saturation mode are captured on the first
//   beat of a vector and carried down the pipeline with every beat of it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        beat handshake
//   in_a, in_b               packed operands, lane 0 in the LSBs
//   in_last                  final beat of the current vector
//   in_signed, in_sat        operand signedness / saturating accumulation (first beat only)
//   out_valid/out_ready      result handshake; result held stable while stalled
//   out_sum                  accumulated dot product
//   out_count                beats in the vector (1..MAX_BEATS)
//   out_ovf                  overflow seen anywhere in the vector
//   out_trunc                vector was closed by MAX_BEATS rather than in_last

module dot_accum_unit #(
  parameter int LANES       = 8,
  parameter int INPUT_WIDTH = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int MAX_BEATS   = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*INPUT_WIDTH-1:0] in_a,
  input  logic [LANES*INPUT_WIDTH-1:0] in_b,
  input  logic                         in_last,
  input  logic                         in_signed,
  input  logic                         in_sat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_sum,
  output logic [$clog2(MAX_BEATS):0]   out_count,
  output logic                         out_ovf,
  output logic                         out_trunc
);

  localparam int IW    = INPUT_WIDTH;
  localparam int PW    = 2 * INPUT_WIDTH;
  localparam int TW    = PW + $clog2(LANES);
  localparam int CW    = $clog2(MAX_BEATS) + 1;
  localparam int AW    = ACC_WIDTH;
  localparam int NODES = 2 * LANES - 1;

  // One enable for the whole pipeline: everything moves only when the output
  // register is free or being drained this cycle.
  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // ---------------------------------------------------------------------------
  // Input bookkeeping: beat counter and per-vector mode capture
  // ---------------------------------------------------------------------------
  logic [CW-1:0] beat_cnt;     // beats already accepted in the open vector
  logic [CW-1:0] beat_num;     // 1-based index of the beat being offered
  logic          mode_signed;
  logic          mode_sat;
  logic          first_beat;
  logic          hit_max;
  logic          close_beat;
  logic          beat_signed;
  logic          beat_sat;

  always_comb begin
    first_beat  = (beat_cnt == '0);
    beat_num    = beat_cnt + CW'(1);
    hit_max     = (beat_num == CW'(MAX_BEATS));
    close_beat  = in_last || hit_max;
    // Later beats of a vector ignore their own mode inputs.
    beat_signed = first_beat ? in_signed : mode_signed;
    beat_sat    = first_beat ? in_sat    : mode_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      mode_signed <= 1'b0;
      mode_sat    <= 1'b0;
    end else if (accept) begin
      beat_cnt <= close_beat ? '0 : beat_num;
      if (first_beat) begin
        mode_signed <= in_signed;
        mode_sat    <= in_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane multipliers
  // ---------------------------------------------------------------------------
  // Operands are extended to PW bits first; the low PW bits of the PW x PW
  // product are then the exact product for both signed and unsigned operands.
  logic [PW-1:0] prod [LANES];

  always_comb begin : mul_blk
    logic [PW-1:0] xa;
    logic [PW-1:0] xb;
    xa = '0;
    xb = '0;
    for (int i = 0; i < LANES; i++) begin
      xa = {{IW{beat_signed & in_a[i*IW + IW-1]}}, in_a[i*IW +: IW]};
      xb = {{IW{beat_signed & in_b[i*IW + IW-1]}}, in_b[i*IW +: IW]};
      prod[i] = xa * xb;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: products and beat attributes
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [PW-1:0] s1_prod [LANES];
  logic          s1_first;
  logic          s1_close;
  logic          s1_trunc;
  logic          s1_signed;
  logic          s1_sat;
  logic [CW-1:0] s1_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod   <= prod;
        s1_first  <= first_beat;
        s1_close  <= close_beat;
        s1_trunc  <= hit_max && !in_last;
        s1_signed <= beat_signed;
        s1_sat    <= beat_sat;
        s1_count  <= beat_num;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree: heap layout, leaves at LANES-1 .. 2*LANES-2, root at 0.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tree_sum;

  always_comb begin : tree_blk
    logic [TW-1:0] node [NODES];
    for (int i = 0; i < LANES; i++) begin
      node[LANES-1+i] = {{(TW-PW){s1_signed & s1_prod[i][PW-1]}}, s1_prod[i]};
    end
    for (int k = LANES - 2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    tree_sum = node[0];
  end

  // ---------------------------------------------------------------------------
  // S2: reduced tree sum
  // ---------------------------------------------------------------------------
  logic          s2_valid;
  logic [TW-1:0] s2_tree;
  logic          s2_first;
  logic          s2_close;
  logic          s2_trunc;
  logic          s2_signed;
  logic          s2_sat;
  logic [CW-1:0] s2_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tree   <= tree_sum;
        s2_first  <= s1_first;
        s2_close  <= s1_close;
        s2_trunc  <= s1_trunc;
        s2_signed <= s1_signed;
        s2_sat    <= s1_sat;
        s2_count  <= s1_count;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: accumulate with one guard bit
  // ---------------------------------------------------------------------------
  logic [AW-1:0] acc;
  logic          acc_ovf;
  logic [AW:0]   base;
  logic [AW:0]   addend;
  logic [AW:0]   sum_wide;
  logic          ovf_now;
  logic [AW-1:0] clamp;
  logic [AW-1:0] acc_next;
  logic          ovf_next;

  always_comb begin
    // First beat of a vector starts from zero, so a stale acc never leaks in.
    base     = s2_first ? '0 : {s2_signed & acc[AW-1], acc};
    addend   = {{(AW+1-TW){s2_signed & s2_tree[TW-1]}}, s2_tree};
    sum_wide = base + addend;
    // Signed: guard bit disagreeing with the ACC_WIDTH sign bit means the
    // result left the signed range. Unsigned: the guard bit is the carry out.
    ovf_now  = s2_signed ? (sum_wide[AW] ^ sum_wide[AW-1]) : sum_wide[AW];
    // In signed mode the guard bit is the true sign, selecting min or max.
    if (!s2_signed) begin
      clamp = '1;
    end else if (sum_wide[AW]) begin
      clamp = {1'b1, {(AW-1){1'b0}}};
    end else begin
      clamp = {1'b0, {(AW-1){1'b1}}};
    end
    acc_next = (ovf_now && s2_sat) ? clamp : sum_wide[AW-1:0];
    ovf_next = (!s2_first && acc_ovf) || ovf_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else if (en) begin
      if (s2_valid) begin
        acc     <= acc_next;
        acc_ovf <= ovf_next;
      end
      // A closing beat reloads the output in the same cycle the previous
      // result is taken, so back-to-back vectors need no bubble.
      out_valid <= s2_valid && s2_close;
      if (s2_valid && s2_close) begin
        out_sum   <= acc_next;
        out_count <= s2_count;
        out_ovf   <= ovf_next;
        out_trunc <= s2_trunc;
      end
    end
  end

endmodule
